// File: rtl/main_stream_tx_if.sv
// Tile-in / word-out bundle for the main-buffer load stream.
//   master : tile producer and stream consumer (drives tile_*, observes tx_*)
//   slave  : main_stream_tx (accepts tiles, drives the 8-slot word stream)
// Signals: tile_valid/tile_ready handshake, tile_ifm/tile_wgt (9 packed
// bytes, element i in [8i+7:8i]), tile_bias, tx_data/tx_valid/tx_kind/
// tx_sop/frame_done towards main_input.
interface main_stream_tx_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ELEM_WIDTH = 8,
  parameter int unsigned NUM_ELEMS  = 9
);
  logic                            tile_valid;
  logic                            tile_ready;
  logic [NUM_ELEMS*ELEM_WIDTH-1:0] tile_ifm;
  logic [NUM_ELEMS*ELEM_WIDTH-1:0] tile_wgt;
  logic [ELEM_WIDTH-1:0]           tile_bias;
  logic [DATA_WIDTH-1:0]           tx_data;
  logic                            tx_valid;
  logic [1:0]                      tx_kind;
  logic                            tx_sop;
  logic                            frame_done;

  modport master (
    output tile_valid, tile_ifm, tile_wgt, tile_bias,
    input  tile_ready, tx_data, tx_valid, tx_kind, tx_sop, frame_done
  );

  modport slave (
    input  tile_valid, tile_ifm, tile_wgt, tile_bias,
    output tile_ready, tx_data, tx_valid, tx_kind, tx_sop, frame_done
  );
endinterface

// File: rtl/main_stream_tx.sv
// Transmit end of the main-buffer load stream. Takes one tile per handshake
// and serialises it into the fixed 8-slot frame consumed by the buffer demux:
// slots 0-2 IFM, 3-5 WGT, 6 BIAS, 7 idle. The slot counter free-runs in
// lockstep with the buffer's own counter (both cleared by the shared rst_n).
// Ports:
//   clk    : clock, all logic on posedge
//   rst_n  : synchronous active-low reset
//   bus    : slave side of main_stream_tx_if (tile handshake in, tx_* out)
module main_stream_tx #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ELEM_WIDTH     = 8,
  parameter int unsigned NUM_ELEMS      = 9,
  parameter int unsigned ELEMS_PER_WORD = 3
) (
  input logic             clk,
  input logic             rst_n,
  main_stream_tx_if.slave bus
);

  localparam int unsigned TILE_W = NUM_ELEMS * ELEM_WIDTH;
  localparam int unsigned WORD_W = ELEMS_PER_WORD * ELEM_WIDTH;

  localparam logic [1:0] KIND_IFM  = 2'b01;
  localparam logic [1:0] KIND_WGT  = 2'b10;
  localparam logic [1:0] KIND_BIAS = 2'b11;
  localparam logic [1:0] KIND_IDLE = 2'b00;

  logic [2:0]            slot;
  logic                  pending_full;
  logic [TILE_W-1:0]     pend_ifm;
  logic [TILE_W-1:0]     pend_wgt;
  logic [ELEM_WIDTH-1:0] pend_bias;
  logic                  active_valid;
  logic [TILE_W-1:0]     act_ifm;
  logic [TILE_W-1:0]     act_wgt;
  logic [ELEM_WIDTH-1:0] act_bias;
  logic                  accept;

  logic [WORD_W-1:0]     word;
  logic [1:0]            kind;
  logic [DATA_WIDTH-1:0] data;

  // Ready depends on registered state only, so no comb path from tile_valid.
  assign accept         = bus.tile_valid & ~pending_full;
  assign bus.tile_ready = ~pending_full;

  // Slot counter, pending/active tile registers and frame load at slot 7.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot         <= 3'd0;
      pending_full <= 1'b0;
      pend_ifm     <= '0;
      pend_wgt     <= '0;
      pend_bias    <= '0;
      active_valid <= 1'b0;
      act_ifm      <= '0;
      act_wgt      <= '0;
      act_bias     <= '0;
    end else begin
      slot <= slot + 3'd1;
      if (slot == 3'd7) begin
        if (pending_full) begin
          act_ifm      <= pend_ifm;
          act_wgt      <= pend_wgt;
          act_bias     <= pend_bias;
          active_valid <= 1'b1;
          pending_full <= 1'b0;
        end else if (accept) begin
          // Bypass: a tile offered in slot 7 goes straight to active.
          act_ifm      <= bus.tile_ifm;
          act_wgt      <= bus.tile_wgt;
          act_bias     <= bus.tile_bias;
          active_valid <= 1'b1;
        end else begin
          active_valid <= 1'b0;
        end
      end else if (accept) begin
        pend_ifm     <= bus.tile_ifm;
        pend_wgt     <= bus.tile_wgt;
        pend_bias    <= bus.tile_bias;
        pending_full <= 1'b1;
      end
    end
  end

  // Slot-to-word mux; kind follows the slot even in idle frames.
  always_comb begin
    word = '0;
    kind = KIND_IDLE;
    case (slot)
      3'd0: begin kind = KIND_IFM;  word = act_ifm[0*WORD_W +: WORD_W]; end
      3'd1: begin kind = KIND_IFM;  word = act_ifm[1*WORD_W +: WORD_W]; end
      3'd2: begin kind = KIND_IFM;  word = act_ifm[2*WORD_W +: WORD_W]; end
      3'd3: begin kind = KIND_WGT;  word = act_wgt[0*WORD_W +: WORD_W]; end
      3'd4: begin kind = KIND_WGT;  word = act_wgt[1*WORD_W +: WORD_W]; end
      3'd5: begin kind = KIND_WGT;  word = act_wgt[2*WORD_W +: WORD_W]; end
      3'd6: begin kind = KIND_BIAS; end
      default: begin kind = KIND_IDLE; end
    endcase

    data = '0;
    if (active_valid && slot != 3'd7) begin
      if (slot == 3'd6) begin
        data = DATA_WIDTH'($signed(act_bias));
      end else begin
        data = DATA_WIDTH'(word);
      end
    end
  end

  assign bus.tx_data    = data;
  assign bus.tx_kind    = kind;
  assign bus.tx_valid   = active_valid & (slot != 3'd7);
  assign bus.tx_sop     = (slot == 3'd0);
  assign bus.frame_done = active_valid & (slot == 3'd6);

endmodule
